hash_seq_ctrl: RTL

- Sequences one message hash on the 512-bit chaining state.
- Loads the four 128-bit initial-hash words from the IV table one word per cycle via a 2-bit select.
- Accepts message blocks through a valid/ready handshake and drives the external compression core with a start/done handshake.
- Applies per-lane feed-forward after each block and presents the final digest through a valid/ready output.

---
 rtl/hash_pkg.sv | 28 ++
 rtl/hash_feedfwd.sv | 29 ++
 rtl/hash_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// ---------------------------------------------------------------------------
// hash_pkg
// Shared definitions for the hash sequencer: datapath widths, the chaining
// state and lane-array types, and the sequencer FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package hash_pkg;

  localparam int STATE_W  = 512;               // chaining state width
  localparam int WORD_W   = 128;               // one IV table word
  localparam int LANE_W   = 64;                // feed-forward lane width
  localparam int IV_WORDS = 4;                 // IV words per chaining state
  localparam int CNT_W    = 32;                // processed-block counter width
  localparam int LANES    = STATE_W / LANE_W;  // feed-forward lanes

  typedef logic [STATE_W-1:0]            state_t;
  typedef logic [LANES-1:0][LANE_W-1:0]  lane_arr_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_IV  = 3'd1,
    ST_WAIT_BLK = 3'd2,
    ST_COMPRESS = 3'd3,
    ST_FEEDFWD  = 3'd4,
    ST_OUTPUT   = 3'd5
  } fsm_e;

endpackage

// File: rtl/hash_feedfwd.sv
// ---------------------------------------------------------------------------
// hash_feedfwd
// Combinational per-lane feed-forward: each LANE_W-bit lane of the chaining
// state is added to the matching lane of the compression result modulo
// 2^LANE_W. Carries never cross a lane boundary.
// Ports:
//   i_state  - current chaining state
//   i_result - compression core output
//   o_sum    - lane-wise modular sum (new chaining state)
// ---------------------------------------------------------------------------
module hash_feedfwd
  import hash_pkg::*;
#(
  parameter int LANE_W = hash_pkg::LANE_W
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic [STATE_W-1:0] i_result,
  output logic [STATE_W-1:0] o_sum
);

  localparam int N_LANES = STATE_W / LANE_W;

  // Each lane is its own adder, so a lane overflow simply wraps.
  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    assign o_sum[g*LANE_W +: LANE_W] = i_state[g*LANE_W +: LANE_W]
                                     + i_result[g*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/hash_seq_ctrl.sv
// ---------------------------------------------------------------------------
// hash_seq_ctrl
// Sequences one message hash over the 512-bit chaining state: loads the IV
// one 128-bit word per cycle, accepts message blocks, launches the external
// compression core, applies lane-wise feed-forward and returns the digest.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   start                       - begin a message (honoured only when idle)
//   iv_sel / iv_word            - IV table select and its same-cycle word
//   blk_valid/blk_ready/blk_data/blk_last - message block handshake
//   core_start/core_state/core_msg        - compression launch and operands
//   core_done/core_result                 - compression completion
//   digest_valid/digest_ready/digest      - digest output handshake
//   blk_count                   - blocks processed in the current message
//   busy                        - high whenever not idle
// ---------------------------------------------------------------------------
module hash_seq_ctrl
  import hash_pkg::*;
#(
  parameter  int IV_WORDS = hash_pkg::IV_WORDS,
  parameter  int LANE_W   = hash_pkg::LANE_W,
  parameter  int CNT_W    = hash_pkg::CNT_W,
  localparam int SEL_W    = $clog2(IV_WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [SEL_W-1:0]   iv_sel,
  input  logic [WORD_W-1:0]  iv_word,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [STATE_W-1:0] blk_data,
  input  logic               blk_last,
  output logic               core_start,
  output logic [STATE_W-1:0] core_state,
  output logic [STATE_W-1:0] core_msg,
  input  logic               core_done,
  input  logic [STATE_W-1:0] core_result,
  output logic               digest_valid,
  input  logic               digest_ready,
  output logic [STATE_W-1:0] digest,
  output logic [CNT_W-1:0]   blk_count,
  output logic               busy
);

  fsm_e             r_state;
  fsm_e             w_state_nx;
  logic [SEL_W-1:0] r_iv_cnt;
  state_t           r_chain;
  state_t           r_msg;
  state_t           r_result;
  state_t           r_digest;
  state_t           w_ff_sum;
  logic             r_last;
  logic             r_core_start;
  logic             r_blk_ready;
  logic             r_digest_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_blk_count;
  logic             w_iv_last;
  logic             w_done_ok;

  assign w_iv_last = (r_iv_cnt == SEL_W'(IV_WORDS - 1));
  // r_core_start marks the first COMPRESS cycle; a done there is stale.
  assign w_done_ok = core_done && !r_core_start;

  hash_feedfwd #(
    .LANE_W (LANE_W)
  ) u_feedfwd (
    .i_state  (r_chain),
    .i_result (r_result),
    .o_sum    (w_ff_sum)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nx = ST_LOAD_IV;
        else       w_state_nx = ST_IDLE;
      end
      ST_LOAD_IV: begin
        if (w_iv_last) w_state_nx = ST_WAIT_BLK;
        else           w_state_nx = ST_LOAD_IV;
      end
      ST_WAIT_BLK: begin
        if (blk_valid) w_state_nx = ST_COMPRESS;
        else           w_state_nx = ST_WAIT_BLK;
      end
      ST_COMPRESS: begin
        if (w_done_ok) w_state_nx = ST_FEEDFWD;
        else           w_state_nx = ST_COMPRESS;
      end
      ST_FEEDFWD: begin
        if (r_last) w_state_nx = ST_OUTPUT;
        else        w_state_nx = ST_WAIT_BLK;
      end
      ST_OUTPUT: begin
        if (digest_ready) w_state_nx = ST_IDLE;
        else              w_state_nx = ST_OUTPUT;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iv_cnt       <= '0;
      r_chain        <= '0;
      r_msg          <= '0;
      r_result       <= '0;
      r_digest       <= '0;
      r_last         <= 1'b0;
      r_core_start   <= 1'b0;
      r_blk_ready    <= 1'b0;
      r_digest_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_blk_count    <= '0;
    end else begin
      // Flags are registered from the next state so they line up with it.
      r_core_start   <= (r_state == ST_WAIT_BLK) && blk_valid;
      r_blk_ready    <= (w_state_nx == ST_WAIT_BLK);
      r_digest_valid <= (w_state_nx == ST_OUTPUT);
      r_busy         <= (w_state_nx != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_iv_cnt    <= '0;
            r_blk_count <= '0;
          end
        end
        ST_LOAD_IV: begin
          for (int w = 0; w < IV_WORDS; w++) begin
            if (r_iv_cnt == SEL_W'(w)) r_chain[w*WORD_W +: WORD_W] <= iv_word;
          end
          r_iv_cnt <= r_iv_cnt + SEL_W'(1);
        end
        ST_WAIT_BLK: begin
          if (blk_valid) begin
            r_msg  <= blk_data;
            r_last <= blk_last;
          end
        end
        ST_COMPRESS: begin
          if (w_done_ok) r_result <= core_result;
        end
        ST_FEEDFWD: begin
          r_chain     <= w_ff_sum;
          r_blk_count <= r_blk_count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_last) r_digest <= w_ff_sum;
        end
        default: begin
          r_iv_cnt <= r_iv_cnt;
        end
      endcase
    end
  end

  assign iv_sel       = r_iv_cnt;
  assign blk_ready    = r_blk_ready;
  assign core_start   = r_core_start;
  assign core_state   = r_chain;
  assign core_msg     = r_msg;
  assign digest_valid = r_digest_valid;
  assign digest       = r_digest;
  assign blk_count    = r_blk_count;
  assign busy         = r_busy;

endmodule
